// File: rtl/axis_pkt_arb_4ch_if.sv
// Bundle of channel-side inputs, merged stream, and status for the 4-channel packet arbiter.
// The slave modport faces the arbiter; the master modport faces whatever drives and observes it.
interface axis_pkt_arb_4ch_if #(
    parameter int unsigned P_DATA_W = 8,
    parameter int unsigned P_USER_W = 16,
    parameter int unsigned P_CNT_W  = 16
);
    logic [3:0]            i_ch_en;
    logic [4*P_DATA_W-1:0] i_ch_axis_data;
    logic [4*P_USER_W-1:0] i_ch_axis_user;
    logic [3:0]            i_ch_axis_valid;
    logic [3:0]            i_ch_axis_last;
    logic [3:0]            o_ch_axis_ready;
    logic [P_DATA_W-1:0]   o_post_axis_data;
    logic [P_USER_W-1:0]   o_post_axis_user;
    logic                  o_post_axis_valid;
    logic                  o_post_axis_last;
    logic                  i_post_axis_ready;
    logic [3:0]            o_grant;
    logic                  o_busy;
    logic [4*P_CNT_W-1:0]  o_pkt_cnt;

    modport slave (
        input  i_ch_en, i_ch_axis_data, i_ch_axis_user, i_ch_axis_valid, i_ch_axis_last,
        input  i_post_axis_ready,
        output o_ch_axis_ready, o_post_axis_data, o_post_axis_user, o_post_axis_valid,
        output o_post_axis_last, o_grant, o_busy, o_pkt_cnt
    );

    modport master (
        output i_ch_en, i_ch_axis_data, i_ch_axis_user, i_ch_axis_valid, i_ch_axis_last,
        output i_post_axis_ready,
        input  o_ch_axis_ready, o_post_axis_data, o_post_axis_user, o_post_axis_valid,
        input  o_post_axis_last, o_grant, o_busy, o_pkt_cnt
    );
endinterface

// File: rtl/axis_pkt_arb_4ch.sv
// Four-channel AXI-Stream packet arbiter: round-robin grant per whole packet, one idle
// cycle between packets, and a wrapping completed-packet counter per channel.
module axis_pkt_arb_4ch #(
    parameter int unsigned P_DATA_W = 8,
    parameter int unsigned P_USER_W = 16,
    parameter int unsigned P_CNT_W  = 16
) (
    input logic              i_post_clk,
    input logic              i_post_rst,
    axis_pkt_arb_4ch_if.slave axis
);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e             state_q;
    logic [3:0]         grant_q;
    logic [1:0]         gidx_q;
    logic [1:0]         r_last_q;
    logic               busy_q;
    logic [P_CNT_W-1:0] cnt_q [4];

    logic [3:0] req;
    logic [1:0] pick_idx;
    logic       sel_valid;
    logic       sel_last;
    logic       beat_fire;

    assign req       = axis.i_ch_axis_valid & axis.i_ch_en;
    assign sel_valid = axis.i_ch_axis_valid[gidx_q];
    assign sel_last  = axis.i_ch_axis_last[gidx_q];
    assign beat_fire = (state_q == StXfer) && sel_valid && axis.i_post_axis_ready;

    // Round-robin search starting one past the last granted channel, wrapping at 4.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        idx      = '0;
        found    = 1'b0;
        pick_idx = r_last_q;
        for (int i = 1; i <= 4; i++) begin
            idx = r_last_q + 2'(i);
            if (!found && req[idx]) begin
                pick_idx = idx;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge i_post_clk or posedge i_post_rst) begin
        if (i_post_rst) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            gidx_q   <= '0;
            r_last_q <= 2'd3;
            busy_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req) begin
                        state_q  <= StXfer;
                        grant_q  <= 4'b0001 << pick_idx;
                        gidx_q   <= pick_idx;
                        r_last_q <= pick_idx;
                        busy_q   <= 1'b1;
                    end
                end
                StXfer: begin
                    if (beat_fire && sel_last) begin
                        state_q        <= StIdle;
                        grant_q        <= '0;
                        busy_q         <= 1'b0;
                        cnt_q[gidx_q]  <= cnt_q[gidx_q] + P_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Merged stream is a pure mux of the granted channel; everything is quiet while idle.
    always_comb begin
        axis.o_post_axis_data  = '0;
        axis.o_post_axis_user  = '0;
        axis.o_post_axis_valid = 1'b0;
        axis.o_post_axis_last  = 1'b0;
        axis.o_ch_axis_ready   = '0;
        if (state_q == StXfer) begin
            axis.o_post_axis_data  = axis.i_ch_axis_data[gidx_q*P_DATA_W +: P_DATA_W];
            axis.o_post_axis_user  = axis.i_ch_axis_user[gidx_q*P_USER_W +: P_USER_W];
            axis.o_post_axis_valid = sel_valid;
            axis.o_post_axis_last  = sel_last;
            axis.o_ch_axis_ready[gidx_q] = axis.i_post_axis_ready;
        end
    end

    always_comb begin
        axis.o_pkt_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            axis.o_pkt_cnt[k*P_CNT_W +: P_CNT_W] = cnt_q[k];
        end
    end

    assign axis.o_grant = grant_q;
    assign axis.o_busy  = busy_q;

endmodule

// File: tb/tb_axis_pkt_arb_4ch.sv
// Directed bench for axis_pkt_arb_4ch: per-channel beat queues feed the inputs, a monitor
// logs accepted output beats, and each scenario task checks against hand-derived values.
module tb_axis_pkt_arb_4ch;

    localparam int unsigned DW = 8;
    localparam int unsigned UW = 16;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [7:0] d;
        logic [15:0] u;
        logic       l;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    beat_t      bq [4][$];
    rec_t       mon_q [$];
    logic [3:0] hs_s = '0;

    axis_pkt_arb_4ch_if #(.P_DATA_W(DW), .P_USER_W(UW), .P_CNT_W(CW)) bus ();

    axis_pkt_arb_4ch #(.P_DATA_W(DW), .P_USER_W(UW), .P_CNT_W(CW)) dut (
        .i_post_clk (clk),
        .i_post_rst (rst),
        .axis       (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Handshakes are decided on values settled by the falling edge.
    always @(negedge clk) hs_s = bus.o_ch_axis_ready & bus.i_ch_axis_valid;

    always @(posedge clk) begin : drv
        logic rst_e;
        rst_e = rst;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs_s[k] && !rst_e && bq[k].size() > 0) void'(bq[k].pop_front());
            if (bq[k].size() > 0) begin
                bus.i_ch_axis_valid[k]         = 1'b1;
                bus.i_ch_axis_last[k]          = bq[k][0].l;
                bus.i_ch_axis_data[k*DW +: DW] = bq[k][0].d;
                bus.i_ch_axis_user[k*UW +: UW] = {8'(k), bq[k][0].d};
            end else begin
                bus.i_ch_axis_valid[k]         = 1'b0;
                bus.i_ch_axis_last[k]          = 1'b0;
                bus.i_ch_axis_data[k*DW +: DW] = '0;
                bus.i_ch_axis_user[k*UW +: UW] = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.o_post_axis_valid && bus.i_post_axis_ready)
            mon_q.push_back('{cyc, bus.o_grant, bus.o_post_axis_data, bus.o_post_axis_user,
                              bus.o_post_axis_last});
    end

    function automatic logic [CW-1:0] cnt_of(input int k);
        return bus.o_pkt_cnt[k*CW +: CW];
    endfunction

    task automatic push_pkt(input int k, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) bq[k].push_back('{base + 8'(i), (i == n - 1)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) bq[k].delete();
        bus.i_post_axis_ready = 1'b1;
        bus.i_ch_en = 4'hf;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_q.delete();
    endtask

    task automatic wait_drain(input logic [3:0] mask, input string name);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        while (!done && t < 300) begin
            @(negedge clk);
            #1;
            t++;
            done = !bus.o_busy;
            for (int k = 0; k < 4; k++) if (mask[k] && bq[k].size() != 0) done = 1'b0;
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        push_pkt(2, 2, 8'h77);
        repeat (3) @(negedge clk);
        n_vec++; if (bus.o_grant !== 4'b0000) begin n_err++;
            $display("FAIL rst_grant: got %b want 0000", bus.o_grant); end
        n_vec++; if (bus.o_busy !== 1'b0) begin n_err++;
            $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
        n_vec++; if (bus.o_pkt_cnt !== '0) begin n_err++;
            $display("FAIL rst_cnt: got %h want 0", bus.o_pkt_cnt); end
        n_vec++; if (bus.o_post_axis_valid !== 1'b0 || bus.o_post_axis_last !== 1'b0) begin
            n_err++; $display("FAIL rst_valid: got v=%b l=%b want 0 0",
                              bus.o_post_axis_valid, bus.o_post_axis_last); end
        n_vec++; if (bus.o_ch_axis_ready !== 4'b0000) begin n_err++;
            $display("FAIL rst_ready: got %b want 0000", bus.o_ch_axis_ready); end
        n_vec++; if (bus.o_post_axis_data !== '0 || bus.o_post_axis_user !== '0) begin n_err++;
            $display("FAIL rst_data: got %h/%h want 0/0", bus.o_post_axis_data,
                     bus.o_post_axis_user); end
        do_reset();
    endtask

    task automatic test_round_robin();
        int k, i, gap;
        logic [3:0] eg;
        logic [7:0] ed;
        do_reset();
        for (int c = 0; c < 4; c++) push_pkt(c, 3, 8'(c * 16));
        wait_drain(4'hf, "rr");
        n_vec++; if (mon_q.size() != 12) begin n_err++;
            $display("FAIL rr_beats: got %0d want 12", mon_q.size()); end
        for (int b = 0; b < 12 && b < mon_q.size(); b++) begin
            k = b / 3; i = b % 3;
            eg = 4'(1 << k);
            ed = 8'(k * 16 + i);
            n_vec++; if (mon_q[b].g !== eg || mon_q[b].d !== ed || mon_q[b].l !== (i == 2)
                        || mon_q[b].u !== {8'(k), ed}) begin n_err++;
                $display("FAIL rr_beat%0d: got g=%b d=%h u=%h l=%b want g=%b d=%h u=%h l=%b",
                         b, mon_q[b].g, mon_q[b].d, mon_q[b].u, mon_q[b].l, eg, ed,
                         {8'(k), ed}, (i == 2)); end
            if (b > 0) begin
                gap = (i == 0) ? 2 : 1;
                n_vec++; if (mon_q[b].cyc - mon_q[b-1].cyc != gap) begin n_err++;
                    $display("FAIL rr_gap%0d: got %0d want %0d", b,
                             mon_q[b].cyc - mon_q[b-1].cyc, gap); end
            end
        end
        for (int c = 0; c < 4; c++) begin
            n_vec++; if (cnt_of(c) !== CW'(1)) begin n_err++;
                $display("FAIL rr_cnt%0d: got %0d want 1", c, cnt_of(c)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ed [4];
        int eg [4];
        ed = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
        eg = '{0, 1, 2, 1};
        do_reset();
        push_pkt(2, 2, 8'hA0);
        push_pkt(2, 2, 8'hB0);
        wait_drain(4'b0100, "b2b");
        n_vec++; if (mon_q.size() != 4) begin n_err++;
            $display("FAIL b2b_beats: got %0d want 4", mon_q.size()); end
        for (int b = 0; b < 4 && b < mon_q.size(); b++) begin
            n_vec++; if (mon_q[b].g !== 4'b0100 || mon_q[b].d !== ed[b]) begin n_err++;
                $display("FAIL b2b_beat%0d: got g=%b d=%h want g=0100 d=%h", b, mon_q[b].g,
                         mon_q[b].d, ed[b]); end
            if (b > 0) begin
                n_vec++; if (mon_q[b].cyc - mon_q[b-1].cyc != eg[b]) begin n_err++;
                    $display("FAIL b2b_gap%0d: got %0d want %0d", b,
                             mon_q[b].cyc - mon_q[b-1].cyc, eg[b]); end
            end
        end
        n_vec++; if (cnt_of(2) !== CW'(2)) begin n_err++;
            $display("FAIL b2b_cnt2: got %0d want 2", cnt_of(2)); end
    endtask

    task automatic test_stall();
        logic [3:0] er;
        do_reset();
        push_pkt(1, 4, 8'h50);
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (bus.o_busy) begin
                er = {2'b00, bus.i_post_axis_ready, 1'b0};
                n_vec++; if (bus.o_ch_axis_ready !== er || bus.o_grant !== 4'b0010) begin
                    n_err++; $display("FAIL stall_ready: got rdy=%b g=%b want rdy=%b g=0010",
                                      bus.o_ch_axis_ready, bus.o_grant, er); end
            end
            @(posedge clk);
            #1 bus.i_post_axis_ready = ~bus.i_post_axis_ready;
        end
        bus.i_post_axis_ready = 1'b1;
        wait_drain(4'b0010, "stall");
        n_vec++; if (mon_q.size() != 4) begin n_err++;
            $display("FAIL stall_beats: got %0d want 4", mon_q.size()); end
        for (int b = 0; b < 4 && b < mon_q.size(); b++) begin
            n_vec++; if (mon_q[b].d !== 8'h50 + 8'(b) || mon_q[b].l !== (b == 3)) begin n_err++;
                $display("FAIL stall_beat%0d: got d=%h l=%b want d=%h l=%b", b, mon_q[b].d,
                         mon_q[b].l, 8'h50 + 8'(b), (b == 3)); end
        end
        n_vec++; if (cnt_of(1) !== CW'(1)) begin n_err++;
            $display("FAIL stall_cnt1: got %0d want 1", cnt_of(1)); end
    endtask

    task automatic test_enable_mask();
        int t;
        do_reset();
        bus.i_ch_en = 4'b1110;
        push_pkt(0, 2, 8'h10);
        push_pkt(1, 3, 8'h20);
        t = 0;
        while (!bus.o_busy && t < 20) begin
            @(negedge clk);
            t++;
            n_vec++; if (bus.o_ch_axis_ready[0] !== 1'b0) begin n_err++;
                $display("FAIL en_rdy0: got 1 want 0"); end
        end
        n_vec++; if (bus.o_grant !== 4'b0010) begin n_err++;
            $display("FAIL en_grant: got %b want 0010", bus.o_grant); end
        // Dropping every enable mid-packet must not disturb the packet in flight.
        @(posedge clk);
        #1 bus.i_ch_en = 4'b0000;
        wait_drain(4'b0010, "en");
        n_vec++; if (mon_q.size() != 3) begin n_err++;
            $display("FAIL en_beats: got %0d want 3", mon_q.size()); end
        for (int b = 0; b < 3 && b < mon_q.size(); b++) begin
            n_vec++; if (mon_q[b].g !== 4'b0010 || mon_q[b].d !== 8'h20 + 8'(b)) begin n_err++;
                $display("FAIL en_beat%0d: got g=%b d=%h want g=0010 d=%h", b, mon_q[b].g,
                         mon_q[b].d, 8'h20 + 8'(b)); end
        end
        n_vec++; if (cnt_of(0) !== CW'(0) || cnt_of(1) !== CW'(1)) begin n_err++;
            $display("FAIL en_cnt: got %0d/%0d want 0/1", cnt_of(0), cnt_of(1)); end
        n_vec++; if (bq[0].size() != 2) begin n_err++;
            $display("FAIL en_ch0_held: got %0d beats left want 2", bq[0].size()); end
    endtask

    task automatic test_valid_gap();
        int t;
        do_reset();
        bq[3].push_back('{8'h30, 1'b0});
        bq[3].push_back('{8'h31, 1'b0});
        t = 0;
        while (bq[3].size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_vec++; if (bq[3].size() != 0) begin n_err++;
            $display("FAIL gap_start: got %0d beats left want 0", bq[3].size()); end
        repeat (3) begin
            @(negedge clk);
            n_vec++; if (bus.o_busy !== 1'b1 || bus.o_grant !== 4'b1000
                        || bus.o_post_axis_valid !== 1'b0) begin n_err++;
                $display("FAIL gap_hold: got busy=%b g=%b v=%b want 1 1000 0", bus.o_busy,
                         bus.o_grant, bus.o_post_axis_valid); end
        end
        bq[3].push_back('{8'h32, 1'b1});
        wait_drain(4'b1000, "gap");
        n_vec++; if (mon_q.size() != 3) begin n_err++;
            $display("FAIL gap_beats: got %0d want 3", mon_q.size()); end
        for (int b = 0; b < 3 && b < mon_q.size(); b++) begin
            n_vec++; if (mon_q[b].d !== 8'h30 + 8'(b) || mon_q[b].l !== (b == 2)) begin n_err++;
                $display("FAIL gap_beat%0d: got d=%h l=%b want d=%h l=%b", b, mon_q[b].d,
                         mon_q[b].l, 8'h30 + 8'(b), (b == 2)); end
        end
        n_vec++; if (cnt_of(3) !== CW'(1)) begin n_err++;
            $display("FAIL gap_cnt3: got %0d want 1", cnt_of(3)); end
    endtask

    task automatic test_reset_mid();
        int t;
        do_reset();
        push_pkt(0, 5, 8'h40);
        t = 0;
        while (mon_q.size() < 2 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        // Beat 2 is on the bus now; reset lands before it can be accepted.
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.o_busy !== 1'b0 || bus.o_grant !== 4'b0000) begin n_err++;
            $display("FAIL rmid_state: got busy=%b g=%b want 0 0000", bus.o_busy, bus.o_grant); end
        n_vec++; if (bus.o_pkt_cnt !== '0 || bus.o_post_axis_valid !== 1'b0) begin n_err++;
            $display("FAIL rmid_out: got cnt=%h v=%b want 0 0", bus.o_pkt_cnt,
                     bus.o_post_axis_valid); end
        mon_q.delete();
        rst = 1'b0;
        wait_drain(4'b0001, "rmid");
        n_vec++; if (mon_q.size() != 4) begin n_err++;
            $display("FAIL rmid_beats: got %0d want 4", mon_q.size()); end
        for (int b = 0; b < 4 && b < mon_q.size(); b++) begin
            n_vec++; if (mon_q[b].d !== 8'h41 + 8'(b) || mon_q[b].l !== (b == 3)) begin n_err++;
                $display("FAIL rmid_beat%0d: got d=%h l=%b want d=%h l=%b", b, mon_q[b].d,
                         mon_q[b].l, 8'h41 + 8'(b), (b == 3)); end
        end
        n_vec++; if (cnt_of(0) !== CW'(1)) begin n_err++;
            $display("FAIL rmid_cnt0: got %0d want 1", cnt_of(0)); end
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) push_pkt(0, 1, 8'(i));
        wait_drain(4'b0001, "wrap_pre");
        n_vec++; if (cnt_of(0) !== CW'(15)) begin n_err++;
            $display("FAIL wrap_pre: got %0d want 15", cnt_of(0)); end
        push_pkt(0, 1, 8'hEE);
        wait_drain(4'b0001, "wrap");
        n_vec++; if (cnt_of(0) !== CW'(0)) begin n_err++;
            $display("FAIL wrap_cnt0: got %0d want 0", cnt_of(0)); end
        n_vec++; if (mon_q.size() != 16) begin n_err++;
            $display("FAIL wrap_beats: got %0d want 16", mon_q.size()); end
    endtask

    initial begin
        bus.i_ch_en           = 4'h0;
        bus.i_ch_axis_data    = '0;
        bus.i_ch_axis_user    = '0;
        bus.i_ch_axis_valid   = '0;
        bus.i_ch_axis_last    = '0;
        bus.i_post_axis_ready = 1'b0;
        #1;
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_stall();
        test_enable_mask();
        test_valid_gap();
        test_reset_mid();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
